// File: rtl/switch_pkg.sv
// Shared types and constants for the switch-phase lock-in demodulator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package switch_pkg;

    // Demodulator control states: waiting for a rising pwm edge, or integrating.
    typedef enum logic [0:0] {
        ALIGN = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Upstream switch PWM: 2.083 kHz at 100 MHz, 50 % duty.
    localparam int PWM_HALF_PERIOD = 24000;
    localparam int PWM_PERIOD      = 2 * PWM_HALF_PERIOD;

    // Default window shaping.
    localparam int DEF_BLANK_SAMPLES = 4;
    localparam int DEF_NUM_PERIODS   = 16;

    // Per-phase sample counters.
    localparam int              COUNT_W   = 16;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

endpackage

// File: rtl/demod_accumulator.sv
// Per-phase signed accumulator with a saturating sample counter and sticky saturation flag.
// Latency: one cycle from add_en/clear to acc/count/sat.
// Backpressure: none; accepts one sample per cycle.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - restart the window; if add_en is also high the sample seeds the new window
//   add_en    - add sample (sign-extended) and bump count
//   sample    - signed input sample
//   acc       - running sum (wraps; sized by the parent so it never does in practice)
//   count     - samples added this window, saturating at all-ones
//   sat       - an increment was attempted while count was already saturated
module demod_accumulator
    import switch_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int ACC_W    = 40
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       add_en,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic signed [ACC_W-1:0]    acc,
    output logic        [COUNT_W-1:0]  count,
    output logic                       sat
);

    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic        [COUNT_W-1:0] count_q, count_d;
    logic                      sat_q, sat_d;

    logic signed [ACC_W-1:0]   acc_base;
    logic        [COUNT_W-1:0] count_base;
    logic                      sat_base;
    logic signed [ACC_W-1:0]   sample_ext;

    always_comb begin
        sample_ext = {{(ACC_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};

        // Clear zeroes the starting point so a coincident add seeds the new window.
        acc_base   = clear ? '0   : acc_q;
        count_base = clear ? '0   : count_q;
        sat_base   = clear ? 1'b0 : sat_q;

        acc_d   = acc_base;
        count_d = count_base;
        sat_d   = sat_base;

        if (add_en) begin
            acc_d = acc_base + sample_ext;
            if (count_base == COUNT_MAX) begin
                sat_d = 1'b1;
            end else begin
                count_d = count_base + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign acc   = acc_q;
    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/switch_demodulator.sv
// Chopper lock-in: integrates samples per pwm phase over NUM_PERIODS periods, emits hi-minus-lo.
// Latency: window-closing rising edge in cycle E -> result/result_valid registered in E+1.
// Backpressure: none; one sample per cycle, result_valid is a one-cycle pulse that cannot stall.
//
// Ports:
//   clk, rst                    - clock, synchronous active-high reset (also clears latched outputs)
//   enable                      - low drops the partial window and forces realignment
//   pwm                         - switch phase, same clock domain
//   sample_data / sample_valid  - signed ADC sample and its qualifier
//   result                      - acc_hi - acc_lo of the last completed window
//   count_hi / count_lo         - samples integrated per phase in the last window
//   result_valid                - pulses when result/counts/overflow update
//   overflow                    - a phase count saturated during the last window
//   aligned                     - high while a window is being integrated
module switch_demodulator
    import switch_pkg::*;
#(
    parameter int SAMPLE_W      = 16,
    parameter int ACC_W         = 40,
    parameter int BLANK_SAMPLES = DEF_BLANK_SAMPLES,
    parameter int NUM_PERIODS   = DEF_NUM_PERIODS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       pwm,
    input  logic signed [SAMPLE_W-1:0] sample_data,
    input  logic                       sample_valid,
    output logic signed [ACC_W-1:0]    result,
    output logic        [COUNT_W-1:0]  count_hi,
    output logic        [COUNT_W-1:0]  count_lo,
    output logic                       result_valid,
    output logic                       overflow,
    output logic                       aligned
);

    localparam int BLANK_W = (BLANK_SAMPLES > 0) ? $clog2(BLANK_SAMPLES + 1) : 1;
    localparam int PER_W   = (NUM_PERIODS > 1)   ? $clog2(NUM_PERIODS)       : 1;
    localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_SAMPLES);
    localparam logic [PER_W-1:0]   PER_LAST   = PER_W'(NUM_PERIODS - 1);

    state_e                    state_q, state_d;
    logic                      pwm_q;
    logic [BLANK_W-1:0]        blank_q, blank_d;
    logic [PER_W-1:0]          period_q, period_d;

    logic signed [ACC_W-1:0]   result_q;
    logic        [COUNT_W-1:0] count_hi_q, count_lo_q;
    logic                      result_valid_q, overflow_q, aligned_q;

    logic                      rise, fall, pwm_edge;
    logic                      align_now, active, window_close;
    logic [BLANK_W-1:0]        blank_eff;
    logic                      take, acc_clear, add_hi, add_lo;

    logic signed [ACC_W-1:0]   acc_hi, acc_lo;
    logic        [COUNT_W-1:0] cnt_hi, cnt_lo;
    logic                      sat_hi, sat_lo;

    always_comb begin
        rise     = pwm & ~pwm_q;
        fall     = ~pwm & pwm_q;
        pwm_edge = rise | fall;

        // The aligning edge is treated like any RUN edge, so its sample is the
        // first blanked sample of the first high phase.
        align_now    = (state_q == ALIGN) && enable && rise;
        active       = ((state_q == RUN) && enable) || align_now;
        window_close = (state_q == RUN) && enable && rise && (period_q == PER_LAST);

        // An edge-cycle sample already belongs to the new phase, so the reload
        // value is what it is tested against.
        blank_eff = pwm_edge ? BLANK_LOAD : blank_q;
        take      = active && sample_valid && (blank_eff == '0);

        blank_d = '0;
        if (active) begin
            if (sample_valid && (blank_eff != '0)) begin
                blank_d = blank_eff - BLANK_W'(1);
            end else begin
                blank_d = blank_eff;
            end
        end

        // Clearing on the closing edge still lets that cycle's sample seed the
        // next window through the accumulator's clear-with-add path.
        acc_clear = !active || align_now || window_close;
        add_hi    = take & pwm;
        add_lo    = take & ~pwm;

        period_d = period_q;
        if (acc_clear) begin
            period_d = '0;
        end else if (rise) begin
            period_d = period_q + PER_W'(1);
        end

        state_d = state_q;
        case (state_q)
            ALIGN:   state_d = align_now ? RUN : ALIGN;
            RUN:     state_d = enable ? RUN : ALIGN;
            default: state_d = ALIGN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ALIGN;
            pwm_q          <= 1'b0;
            blank_q        <= '0;
            period_q       <= '0;
            result_q       <= '0;
            count_hi_q     <= '0;
            count_lo_q     <= '0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            aligned_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            pwm_q          <= pwm;
            blank_q        <= blank_d;
            period_q       <= period_d;
            aligned_q      <= (state_d == RUN);
            result_valid_q <= window_close;
            if (window_close) begin
                result_q   <= acc_hi - acc_lo;
                count_hi_q <= cnt_hi;
                count_lo_q <= cnt_lo;
                overflow_q <= sat_hi | sat_lo;
            end
        end
    end

    demod_accumulator #(
        .SAMPLE_W (SAMPLE_W),
        .ACC_W    (ACC_W)
    ) u_acc_hi (
        .clk    (clk),
        .rst    (rst),
        .clear  (acc_clear),
        .add_en (add_hi),
        .sample (sample_data),
        .acc    (acc_hi),
        .count  (cnt_hi),
        .sat    (sat_hi)
    );

    demod_accumulator #(
        .SAMPLE_W (SAMPLE_W),
        .ACC_W    (ACC_W)
    ) u_acc_lo (
        .clk    (clk),
        .rst    (rst),
        .clear  (acc_clear),
        .add_en (add_lo),
        .sample (sample_data),
        .acc    (acc_lo),
        .count  (cnt_lo),
        .sat    (sat_lo)
    );

    assign result       = result_q;
    assign count_hi     = count_hi_q;
    assign count_lo     = count_lo_q;
    assign result_valid = result_valid_q;
    assign overflow     = overflow_q;
    assign aligned      = aligned_q;

endmodule

// File: doc/switch_demodulator.md
# switch_demodulator

Synchronous demodulator that sits directly downstream of the 2.083 kHz, 50 %-duty switch PWM generator. It consumes that `pwm` square wave plus an ADC sample stream on the same clock. Over a window of `NUM_PERIODS` switch periods it accumulates samples taken while `pwm`=1 and while `pwm`=0 separately, discarding the first `BLANK_SAMPLES` samples after every `pwm` edge. At the end of each window it emits the difference (high minus low), giving a chopper-style lock-in measurement.

## Interface
- `SAMPLE_W`, 16: signed ADC sample width.
- `ACC_W`, 40: signed accumulator/result width; must satisfy ACC_W ≥ SAMPLE_W+17.
- `BLANK_SAMPLES`, 4: valid samples discarded after each `pwm` edge (0 allowed).
- `NUM_PERIODS`, 16: switch periods per window (≥1).
- `clk`  in  1  system clock (100 MHz); only clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  demodulation enable; low forces realignment.
- `pwm`  in  1  switch phase from the PWM generator, same clock domain.
- `sample_data`  in  SAMPLE_W  signed ADC sample.
- `sample_valid`  in  1  qualifies `sample_data` for one cycle.
- `result`  out  ACC_W  signed acc_hi − acc_lo of last window.
- `count_hi` / `count_lo`  out  16 each  samples accumulated per phase in last window.
- `result_valid`  out  1  one-cycle pulse when the outputs update.
- `overflow`  out  1  a count saturated during last window.
- `aligned`  out  1  high while in a window.

## Operation
- `pwm_q` is `pwm` delayed one cycle. A rising edge is `pwm & ~pwm_q`; a falling edge is `~pwm & pwm_q`.
- States:
  - ALIGN: entered from reset or `!enable`. Accumulators, counts, blank counter and period counter are cleared. Samples are ignored. Go to RUN on the first rising edge while `enable`=1.
  - RUN: accumulate.
- In RUN, every edge reloads `blank_cnt` with BLANK_SAMPLES. A valid sample with `blank_cnt`≠0 decrements it and is discarded. Otherwise the sample is sign-extended and added to `acc_hi` (if `pwm`=1) or `acc_lo` (if `pwm`=0), and the matching count is incremented.
- Phase is taken from current `pwm`. A sample on an edge cycle belongs to the new phase and is the first blanked sample.
- Each rising edge in RUN increments `period_cnt`. When it reaches NUM_PERIODS:
  - Latch result = acc_hi − acc_lo, the counts and `overflow`.
  - Pulse `result_valid`.
  - Clear accumulators, counts and `period_cnt`. A sample on that edge cycle seeds the new window, which is blanked.
  - No gap between windows.
- Counts saturate at 0xFFFF. Saturation sets the window's sticky overflow flag. Accumulators wrap (width is sized so they do not).
- `enable` low in RUN: go to ALIGN next cycle and discard the partial window. Latched outputs hold their values.
- `rst` mid-window behaves like `!enable` but also clears the latched outputs.

## Timing
- All outputs are registered.
- Reset values: result=0, count_hi=0, count_lo=0, result_valid=0, overflow=0, aligned=0.
- Latency: a rising edge detected in cycle E that closes a window produces `result`/`result_valid` in E+1. `result` is held until the next window closes.
- `aligned` rises the cycle after the aligning edge and falls the cycle after `enable` drops.
- No back-pressure. One sample per cycle max is accepted. `result_valid` is never blocked.

## Structure
- `switch_pkg`:
  - state enum (ALIGN, RUN);
  - default constants (PWM_HALF_PERIOD=24000, PWM_PERIOD=48000, BLANK_SAMPLES, NUM_PERIODS);
  - count width.
- Sub-module `demod_accumulator` is instantiated twice (hi/lo). Ports: clk, rst, clear, add_en, sample, acc, count, sat.
- Edge detect, blanking, period counter and FSM live in the top.

## Test plan
- Basic window:
  - Setup: BLANK_SAMPLES=2, NUM_PERIODS=2; `pwm` 10 high / 10 low; `sample_valid` every cycle; 100 during high, 40 during low.
  - Required: count_hi=16, count_lo=16, result=1600−640=960; `result_valid` one cycle after the 3rd rising edge.
- Blanking and sign:
  - Setup: BLANK_SAMPLES=0; samples −5 high and +5 low.
  - Required: result = −10·(samples per phase).
  - Setup: BLANK_SAMPLES larger than samples per phase.
  - Required: counts 0, result 0.
- Alignment: `pwm` starts low and samples arrive before the first rising edge. Required: pre-edge samples are excluded; `aligned` rises at E+1.
- Back-to-back windows: run 3 windows with a ramped sample stream. Required: each result matches the model, no sample is lost or double-counted at window boundaries, and a sample on the edge cycle is blanked into the new window.
- Abort: drop `enable` mid-window. Required: no `result_valid`, the previous result is held, and the next window realigns on the next rising edge. Assert `rst` mid-window. Required: all outputs are 0 next cycle.
- Saturation: `pwm` held high for 70000 valid samples. Required: count_hi=0xFFFF and overflow=1 at the window close.
